// File: rtl/pcie_scrambler_nlane.sv
// PCIe Gen1/Gen2 multi-lane data scrambler: NBYTES symbols per clock through one
// G(x)=x^16+x^5+x^4+x^3+1 LFSR chained in byte order, with one registered output stage.
module pcie_scrambler_nlane #(
  parameter int          NBYTES    = 2,
  parameter logic [15:0] LFSR_SEED = 16'hFFFF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [8*NBYTES-1:0]   in_data,
  input  logic [NBYTES-1:0]     in_k,
  input  logic [NBYTES-1:0]     in_noscr,
  input  logic                  scr_bypass,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [8*NBYTES-1:0]   out_data,
  output logic [NBYTES-1:0]     out_k,
  output logic                  lfsr_locked,
  output logic [15:0]           lfsr_state
);

  localparam logic [7:0] SYM_COM = 8'hBC;
  localparam logic [7:0] SYM_SKP = 8'h1C;

  // Eight Galois shifts collapsed into one step; each output bit is s[j-8] plus the
  // feedback taps folded back from the upper byte.
  function automatic logic [15:0] lfsr_adv8(input logic [15:0] s);
    logic [15:0] n;
    n[0]  = s[8];
    n[1]  = s[9];
    n[2]  = s[10];
    n[3]  = s[11] ^ s[8];
    n[4]  = s[12] ^ s[9]  ^ s[8];
    n[5]  = s[13] ^ s[10] ^ s[9]  ^ s[8];
    n[6]  = s[14] ^ s[11] ^ s[10] ^ s[9];
    n[7]  = s[15] ^ s[12] ^ s[11] ^ s[10];
    n[8]  = s[0]  ^ s[13] ^ s[12] ^ s[11];
    n[9]  = s[1]  ^ s[14] ^ s[13] ^ s[12];
    n[10] = s[2]  ^ s[15] ^ s[14] ^ s[13];
    n[11] = s[3]  ^ s[15] ^ s[14];
    n[12] = s[4]  ^ s[15];
    n[13] = s[5];
    n[14] = s[6];
    n[15] = s[7];
    return n;
  endfunction

  logic [15:0]          lfsr_p1;
  logic [15:0]          lfsr_p0;
  logic [8*NBYTES-1:0]  data_p0;
  logic                 com_p0;
  logic                 accept;

  assign in_ready   = !out_valid || out_ready;
  assign accept     = in_valid && in_ready;
  assign lfsr_state = lfsr_p1;

  // Stage 0: walk the beat in byte order, each byte seeing the state left by the previous one.
  always_comb begin
    logic [15:0] s;
    data_p0 = '0;
    com_p0  = 1'b0;
    s       = lfsr_p1;
    for (int i = 0; i < NBYTES; i++) begin
      if (in_k[i]) begin
        data_p0[8*i +: 8] = in_data[8*i +: 8];
        if (in_data[8*i +: 8] == SYM_COM) begin
          s      = LFSR_SEED;
          com_p0 = 1'b1;
        end else if (in_data[8*i +: 8] != SYM_SKP) begin
          s = lfsr_adv8(s);
        end
      end else begin
        if (in_noscr[i] || scr_bypass)
          data_p0[8*i +: 8] = in_data[8*i +: 8];
        else
          data_p0[8*i +: 8] = in_data[8*i +: 8] ^ s[15:8];
        s = lfsr_adv8(s);
      end
    end
    lfsr_p0 = s;
  end

  // Stage 1: output register; LFSR only moves when a beat is actually taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_p1     <= LFSR_SEED;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_k       <= '0;
      lfsr_locked <= 1'b0;
    end else begin
      if (accept) begin
        out_data  <= data_p0;
        out_k     <= in_k;
        out_valid <= 1'b1;
        lfsr_p1   <= lfsr_p0;
        if (com_p0)
          lfsr_locked <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/pcie_scrambler_nlane.md
Name: pcie_scrambler_nlane

Overview:
Registered, parametrised PCIe Gen1/Gen2 data scrambler. It processes NBYTES symbols per clock, time-ordered with byte 0 first, using a single G(x)=x^16+x^5+x^4+x^3+1 LFSR chained across the bytes. It handles COM/SKP/K-symbol rules, per-byte scramble suppression, a global bypass, and a valid/ready handshake with one output register stage. It sits between the TX framing logic and the 8b/10b encoder.

Parameters:
NBYTES, 2, symbols per clock (legal 1, 2, 4); byte i occupies data bits [8i+7:8i]
LFSR_SEED, 16'hFFFF, value loaded at reset and on every COM

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  input beat valid
in_ready  output  1  block accepts beat this cycle
in_data  input  8*NBYTES  symbols
in_k  input  NBYTES  per-byte K-character flag
in_noscr  input  NBYTES  per-byte: pass unscrambled but advance LFSR (TS1/TS2 payload)
scr_bypass  input  1  global: no byte scrambled, LFSR rules still applied
out_valid  output  1  output beat valid
out_ready  input  1  downstream accepts
out_data  output  8*NBYTES  processed symbols
out_k  output  NBYTES  in_k delayed with data
lfsr_locked  output  1  a COM has been seen since reset
lfsr_state  output  16  current LFSR register (debug)

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: lfsr=LFSR_SEED, out_valid=0, out_data=0, out_k=0, lfsr_locked=0. Reset mid-beat discards the registered beat; no partial state survives.
- Handshake: in_ready = !out_valid || out_ready, purely combinational. A beat is accepted when in_valid && in_ready.
- On accept: the output register loads the processed beat, out_valid=1, and the LFSR register takes the post-beat state. Latency is 1 cycle.
- If out_valid && out_ready && no accept: out_valid=0. When stalled (out_valid && !out_ready), out_data, out_k and lfsr hold.
- Per-byte chain: s_0 = lfsr. Byte i uses s_i; s_{i+1} is computed from s_i as follows:
  - k=1 and byte == COM (0xBC): output unscrambled; s_{i+1}=LFSR_SEED; set lfsr_locked=1.
  - k=1 and byte == SKP (0x1C): output unscrambled; s_{i+1}=s_i (no advance).
  - k=1, other value: output unscrambled; LFSR advances 8 steps.
  - k=0: output = byte ^ s_i[15:8] unless in_noscr[i] or scr_bypass, in which case output = byte. LFSR advances 8 steps in all three cases.
- 8-step advance uses the team's standard parallel next-state equations. Example: next[3]=s[8]^s[11], next[8]=s[0]^s[11]^s[12]^s[13], next[15]=s[7].
- COM/SKP are recognised only with k=1; a data byte 0xBC is scrambled normally.
- Any mix of COM/SKP/data within one beat is legal; the chain applies strictly in byte order. A COM at byte NBYTES-1 leaves lfsr=LFSR_SEED for the next beat.
- lfsr_locked clears only on reset.

Test Plan:
- NBYTES=2, reset then beat {byte0=COM k=1, byte1=0x00} -> out {0xBC, 0xFF}; next beat {0x00,0x00} -> {0xE8, then scramble of state 0xE817 advanced}; lfsr_state=0xE817 after byte-1 step observed via NBYTES=1 run; lfsr_locked=1.
- NBYTES=1 sequence COM, SKP, SKP, 0x00 -> 0xBC, 0x1C, 0x1C, 0xFF (SKP does not advance).
- NBYTES=4 beat {COM, 0x00, 0x00(noscr), 0x00} -> {0xBC, 0xFF, 0x00, byte3 scrambled with state after two advances}; compare against NBYTES=1 golden run of the same stream.
- scr_bypass=1 with stream COM,0x5A,0x5A -> output equals input; after clearing bypass, the next data byte is scrambled with the LFSR state advanced by two bytes.
- out_ready held low 3 cycles with in_valid=1 -> in_ready=0, out_data/lfsr_state stable, no beat lost or duplicated on release.
- rst_n pulsed low mid-stream -> out_valid=0 immediately, lfsr_state=0xFFFF, lfsr_locked=0.
